// File: rtl/bet_ledger.sv
// Purpose: betting ledger that locks a wager, deducts the stake and settles the payout into a saturating 8-bit balance.
// Latency: every output is registered and shows the effect of a strobe on the cycle after the strobe is sampled.
// Backpressure: none; a strobe that arrives in a state that cannot use it is dropped. Optional build macro: BANKER_COMMISSION_EN.
module bet_ledger #(
    parameter logic [7:0] INIT_BALANCE = 8'd50,
    parameter logic [3:0] TIE_MULT     = 4'd8,
    parameter logic [7:0] BAL_MAX      = 8'd255
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       betenabled,
    input  logic       updatebalanceenable,
    input  logic       player_win,
    input  logic       dealer_win,
    input  logic [7:0] bet_amount,
    input  logic [1:0] bet_side,
    output logic [7:0] balance,
    output logic [7:0] stake,
    output logic       bet_locked,
    output logic       settle_done,
    output logic       broke
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        BROKE  = 2'd2
    } state_t;

    localparam logic [1:0] SIDE_PLAYER = 2'b00;
    localparam logic [1:0] SIDE_BANKER = 2'b01;
    localparam logic [1:0] SIDE_TIE    = 2'b10;
    localparam logic [1:0] SIDE_BAD    = 2'b11;

    state_t      state_q, state_d;
    logic [7:0]  balance_q, balance_d;
    logic [7:0]  stake_q, stake_d;
    logic [1:0]  side_q, side_d;
    logic        locked_q, locked_d;
    logic        done_q, done_d;
    logic        broke_q, broke_d;

    logic [7:0]  eff;
    logic [11:0] payout;
    logic [11:0] sum;
    logic [7:0]  settled_bal;
    logic        tie, p_only, d_only;

    // Payout for the held wager, computed from the win lights of this cycle.
    always_comb begin
        tie    = player_win & dealer_win;
        p_only = player_win & ~dealer_win;
        d_only = dealer_win & ~player_win;
        payout = 12'd0;
        case (side_q)
            SIDE_PLAYER: begin
                if (p_only)   payout = {3'd0, stake_q, 1'b0};
                else if (tie) payout = {4'd0, stake_q};
            end
            SIDE_BANKER: begin
`ifdef BANKER_COMMISSION_EN
                // House keeps floor(stake/16) of a winning banker bet.
                if (d_only)   payout = {3'd0, stake_q, 1'b0} - {8'd0, stake_q[7:4]};
`else
                if (d_only)   payout = {3'd0, stake_q, 1'b0};
`endif
                else if (tie) payout = {4'd0, stake_q};
            end
            SIDE_TIE: begin
                // Winnings plus returned stake; 9*255 still fits in 12 bits.
                if (tie)      payout = ({8'd0, TIE_MULT} + 12'd1) * {4'd0, stake_q};
            end
            default: payout = 12'd0;
        endcase
        sum         = {4'd0, balance_q} + payout;
        settled_bal = (sum > {4'd0, BAL_MAX}) ? BAL_MAX : sum[7:0];
    end

    // Next-state and next-output logic; nothing changes unless a strobe is accepted.
    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        stake_d   = stake_q;
        side_d    = side_q;
        locked_d  = locked_q;
        done_d    = 1'b0;
        broke_d   = broke_q;
        eff       = (bet_amount < balance_q) ? bet_amount : balance_q;
        case (state_q)
            IDLE: begin
                if (betenabled && eff != 8'd0 && bet_side != SIDE_BAD) begin
                    stake_d   = eff;
                    side_d    = bet_side;
                    balance_d = balance_q - eff;
                    locked_d  = 1'b1;
                    state_d   = LOCKED;
                end
            end
            LOCKED: begin
                // Settlement wins over a coincident bet strobe.
                if (updatebalanceenable) begin
                    balance_d = settled_bal;
                    stake_d   = 8'd0;
                    locked_d  = 1'b0;
                    done_d    = 1'b1;
                    if (settled_bal == 8'd0) begin
                        state_d = BROKE;
                        broke_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BROKE: begin
                broke_d   = 1'b1;
                balance_d = 8'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset forfeits any held stake.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            balance_q <= INIT_BALANCE;
            stake_q   <= 8'd0;
            side_q    <= SIDE_PLAYER;
            locked_q  <= 1'b0;
            done_q    <= 1'b0;
            broke_q   <= (INIT_BALANCE == 8'd0);
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            stake_q   <= stake_d;
            side_q    <= side_d;
            locked_q  <= locked_d;
            done_q    <= done_d;
            broke_q   <= broke_d;
        end
    end

    assign balance     = balance_q;
    assign stake       = stake_q;
    assign bet_locked  = locked_q;
    assign settle_done = done_q;
    assign broke       = broke_q;

endmodule

// File: tb/tb_bet_ledger.sv
// Purpose: directed self-checking bench for bet_ledger with hand-computed expectations.
// Latency: inputs driven on the falling edge, outputs sampled on the following falling edge.
// Backpressure: none; a strobe is held for exactly one rising edge.
module tb_bet_ledger;

    logic       slow_clock;
    logic       resetb;
    logic       betenabled;
    logic       updatebalanceenable;
    logic       player_win;
    logic       dealer_win;
    logic [7:0] bet_amount;
    logic [1:0] bet_side;
    logic [7:0] balance;
    logic [7:0] stake;
    logic       bet_locked;
    logic       settle_done;
    logic       broke;

    int n_checks = 0;
    int n_errors = 0;

    bet_ledger dut (
        .slow_clock          (slow_clock),
        .resetb              (resetb),
        .betenabled          (betenabled),
        .updatebalanceenable (updatebalanceenable),
        .player_win          (player_win),
        .dealer_win          (dealer_win),
        .bet_amount          (bet_amount),
        .bet_side            (bet_side),
        .balance             (balance),
        .stake               (stake),
        .bet_locked          (bet_locked),
        .settle_done         (settle_done),
        .broke               (broke)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of strobes and return to the next falling edge for sampling.
    task automatic cycle(input logic be, input logic ue, input logic [7:0] amt,
                         input logic [1:0] side, input logic pw, input logic dw);
        betenabled          = be;
        updatebalanceenable = ue;
        bet_amount          = amt;
        bet_side            = side;
        player_win          = pw;
        dealer_win          = dw;
        @(negedge slow_clock);
        betenabled          = 1'b0;
        updatebalanceenable = 1'b0;
        player_win          = 1'b0;
        dealer_win          = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        resetb = 1'b0;
        #1;
        resetb = 1'b1;
        @(negedge slow_clock);
    endtask

    int exp_bank;

    initial begin
        resetb = 1'b1;
        betenabled = 1'b0;
        updatebalanceenable = 1'b0;
        player_win = 1'b0;
        dealer_win = 1'b0;
        bet_amount = 8'd0;
        bet_side = 2'b00;
        @(negedge slow_clock);
        resetb = 1'b0;
        #1;
        check("rst_balance", balance, 50);
        check("rst_stake", stake, 0);
        check("rst_locked", bet_locked, 0);
        check("rst_done", settle_done, 0);
        check("rst_broke", broke, 0);
        resetb = 1'b1;
        @(negedge slow_clock);

        // Player bet 20, player wins: 50 -> 30 -> 70.
        cycle(1, 0, 8'd20, 2'b00, 0, 0);
        check("p_lock_bal", balance, 30);
        check("p_lock_stake", stake, 20);
        check("p_lock_flag", bet_locked, 1);
        cycle(0, 1, 8'd0, 2'b00, 1, 0);
        check("p_win_bal", balance, 70);
        check("p_win_stake", stake, 0);
        check("p_win_locked", bet_locked, 0);
        check("p_win_done", settle_done, 1);
        cycle(0, 0, 8'd0, 2'b00, 0, 0);
        check("p_done_pulse", settle_done, 0);
        check("p_hold_bal", balance, 70);

        // Tie bet clamped to balance, tie result saturates at 255.
        do_reset();
        cycle(1, 0, 8'd200, 2'b10, 0, 0);
        check("t_stake", stake, 50);
        check("t_lock_bal", balance, 0);
        check("t_lock_broke", broke, 0);
        cycle(0, 1, 8'd0, 2'b00, 1, 1);
        check("t_sat_bal", balance, 255);
        check("t_sat_broke", broke, 0);

        // All-in banker bet lost: broke is sticky and strobes are ignored.
        do_reset();
        cycle(1, 0, 8'd50, 2'b01, 0, 0);
        cycle(0, 1, 8'd0, 2'b00, 1, 0);
        check("b_lose_bal", balance, 0);
        check("b_lose_broke", broke, 1);
        check("b_lose_done", settle_done, 1);
        cycle(1, 0, 8'd10, 2'b00, 0, 0);
        check("broke_bet_lock", bet_locked, 0);
        check("broke_bet_stake", stake, 0);
        cycle(0, 1, 8'd0, 2'b00, 1, 1);
        check("broke_upd_bal", balance, 0);
        check("broke_upd_done", settle_done, 0);
        check("broke_sticky", broke, 1);

        // Player bet on a tie pushes; invalid side / zero amount / idle settle ignored.
        do_reset();
        cycle(1, 0, 8'd10, 2'b00, 0, 0);
        check("push_lock_bal", balance, 40);
        cycle(0, 1, 8'd0, 2'b00, 1, 1);
        check("push_bal", balance, 50);
        cycle(1, 0, 8'd10, 2'b11, 0, 0);
        check("bad_side_lock", bet_locked, 0);
        check("bad_side_bal", balance, 50);
        cycle(1, 0, 8'd0, 2'b00, 0, 0);
        check("zero_amt_lock", bet_locked, 0);
        cycle(0, 1, 8'd0, 2'b00, 1, 0);
        check("idle_upd_bal", balance, 50);
        check("idle_upd_done", settle_done, 0);

        // No lights high is a loss for the player side.
        cycle(1, 0, 8'd15, 2'b00, 0, 0);
        cycle(0, 1, 8'd0, 2'b00, 0, 0);
        check("nolight_bal", balance, 35);

        // Both strobes in IDLE take the bet; re-bet while locked ignored; async reset forfeits.
        do_reset();
        cycle(1, 1, 8'd5, 2'b00, 1, 0);
        check("both_idle_bal", balance, 45);
        check("both_idle_lock", bet_locked, 1);
        cycle(1, 0, 8'd7, 2'b01, 0, 0);
        check("relock_stake", stake, 5);
        check("relock_bal", balance, 45);
        resetb = 1'b0;
        #1;
        check("midrst_bal", balance, 50);
        check("midrst_lock", bet_locked, 0);
        check("midrst_stake", stake, 0);
        resetb = 1'b1;
        @(negedge slow_clock);

        // Banker bet 32, dealer wins, settled with a coincident bet strobe.
        cycle(1, 0, 8'd32, 2'b01, 0, 0);
        check("bank_lock_bal", balance, 18);
`ifdef BANKER_COMMISSION_EN
        exp_bank = 80;
`else
        exp_bank = 82;
`endif
        cycle(1, 1, 8'd1, 2'b00, 0, 1);
        check("bank_win_bal", balance, exp_bank);
        check("bank_win_lock", bet_locked, 0);
        check("bank_win_done", settle_done, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
